param_clk_divider: RTL
======================

Name: param_clk_divider

Overview:
- Parameterised successor to the fixed divide-by-N counter/toggle block.
- Divides `clk` by a run-time programmable ratio.
- Output modes:
  - square (near-50% duty, handles odd ratios)
  - single-cycle pulse
- Also provides a free-running `tick` strobe.
- Sits between the board clock and slow peripherals (LED blink, debounce sampling, UART baud strobes) in the same synchronous `clk` domain.

Parameters:
- WIDTH, 8, counter and divisor width in bits; maximum ratio 2^WIDTH-1.
- DEFAULT_DIV, 10, divisor loaded at reset; legal range 2..2^WIDTH-1.

Ports:
- clk  input  1  system clock; all logic on posedge.
- r  input  1  synchronous active-high reset.
- en  input  1  count enable; low freezes the divider.
- mode  input  1  0 = square output, 1 = pulse output.
- div_load  input  1  one-cycle strobe: capture `div_in` as the new divisor.
- div_in  input  WIDTH  requested divisor.
- o  output  1  divided clock (registered).
- tick  output  1  one-cycle strobe per period (registered).
- cnt  output  WIDTH  current phase counter value.
- div_cur  output  WIDTH  divisor currently in effect.

Behaviour:
- Synchronous, active-high reset `r`; one clock `clk`. `r` has priority over every other input.
- Reset values:
  - cnt=0, div_cur=DEFAULT_DIV, o=0, tick=0.
  - Shadow divisor = DEFAULT_DIV, pending flag = 0.
- Clamp: any captured `div_in` < 2 is stored as 2.
- Load:
  - div_load=1 writes clamp(div_in) to the shadow register and sets pending. This happens whether `en` is high or low.
  - A later load before the wrap overwrites the shadow; last load wins.
- Count, when en=1:
  - If cnt == div_cur-1 (wrap): cnt<=0; if pending, div_cur<=shadow and pending<=0.
  - Otherwise cnt<=cnt+1.
  - Load in the same cycle as a wrap: div_cur<=clamp(div_in) directly, pending<=0.
- Period equals div_cur cycles of `clk`; the new divisor applies from the first cycle after the wrap. No runt or stretched periods on reprogramming.
- hi = div_cur - (div_cur>>1), i.e. ceil(div_cur/2). Example: div 10 gives hi=5; div 5 gives hi=3.
- Output update, registered with one-cycle lag relative to `cnt`. When en=1:
  - tick <= (cnt == div_cur-1)
  - o <= mode ? (cnt == div_cur-1) : (cnt < hi)
- When en=0:
  - cnt, o, div_cur hold.
  - tick<=0.
  - Load still captured into the shadow.
- Square mode gives `o` high for hi cycles and low for div_cur-hi cycles per period. Odd ratios are high-biased by one cycle.
- `mode` is sampled every cycle. A change mid-period takes effect on the next `o` update; the counter is unaffected.
- If cnt >= div_cur, treat it as a wrap condition (cnt<=0 on the next enabled cycle). This state is unreachable in normal operation.
- All arithmetic is unsigned WIDTH-bit. There is no overflow, since cnt never exceeds div_cur-1.

Optional Feature:
- Macro: CLKDIV_PHASE_SYNC_EN.
- Defined:
  - Adds input port `sync` (1 bit).
  - sync=1 forces cnt<=0 next cycle, regardless of `en`.
  - Any pending shadow divisor is applied immediately and pending<=0.
  - o<=0 and tick<=0 that cycle.
  - sync and div_load together: clamp(div_in) is applied immediately.
  - `r` still has priority over `sync`.
- Undefined: the `sync` port does not exist, and phase changes only via `r` or normal wrap.

Test Plan:
- Reset then en=1, mode=0, default div 10 -> o pattern 5 high/5 low repeating. tick high for one cycle every 10 cycles, in the cycle after cnt=9. div_cur=10.
- div_load with div_in=5 at cnt=3 -> current period completes with 10 cycles. Then div_cur=5, period 5, o 3 high/2 low.
- div_load with div_in=0, then div_in=1 -> div_cur becomes 2 after the wrap. o toggles every cycle; tick every 2 cycles.
- mode=1, div 4 -> o identical to tick: single-cycle pulse every 4 cycles.
- en low for 7 cycles mid-period at cnt=6 -> cnt stays 6, o holds, tick=0. Counting resumes from 6 on re-enable.
- r asserted mid-period with a pending load of 3 -> next cycle cnt=0, o=0, tick=0, div_cur=10, pending discarded.
- With CLKDIV_PHASE_SYNC_EN: sync at cnt=7 -> cnt=0 next cycle. Without the macro, the bench checks that the port is absent.

Source files
------------

// File: rtl/param_clk_divider.sv
// Run-time programmable clock divider with square/pulse output and a period tick.
// Optional CLKDIV_PHASE_SYNC_EN adds a `sync` input that restarts the phase immediately.
module param_clk_divider #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned DEFAULT_DIV = 10
) (
    input  logic             clk,
    input  logic             r,
    input  logic             en,
    input  logic             mode,
    input  logic             div_load,
`ifdef CLKDIV_PHASE_SYNC_EN
    input  logic             sync,
`endif
    input  logic [WIDTH-1:0] div_in,
    output logic             o,
    output logic             tick,
    output logic [WIDTH-1:0] cnt,
    output logic [WIDTH-1:0] div_cur
);

    localparam logic [WIDTH-1:0] DIV_RESET = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] DIV_MIN   = WIDTH'(2);
    localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

    logic [WIDTH-1:0] shadow;
    logic             pending;
    logic [WIDTH-1:0] div_clamped;
    logic [WIDTH-1:0] hi;
    logic             last;
    logic             wrap;

    // Out-of-range counts (cnt >= div_cur) are folded into the wrap condition.
    always_comb begin
        div_clamped = (div_in < DIV_MIN) ? DIV_MIN : div_in;
        hi          = div_cur - (div_cur >> 1);
        last        = (cnt == div_cur - ONE);
        wrap        = (cnt >= div_cur - ONE);
    end

    always_ff @(posedge clk) begin
        if (r) begin
            cnt     <= '0;
            div_cur <= DIV_RESET;
            shadow  <= DIV_RESET;
            pending <= 1'b0;
            o       <= 1'b0;
            tick    <= 1'b0;
        end
`ifdef CLKDIV_PHASE_SYNC_EN
        else if (sync) begin
            cnt  <= '0;
            o    <= 1'b0;
            tick <= 1'b0;
            if (div_load) begin
                div_cur <= div_clamped;
                shadow  <= div_clamped;
                pending <= 1'b0;
            end else if (pending) begin
                div_cur <= shadow;
                pending <= 1'b0;
            end
        end
`endif
        else begin
            if (en) begin
                tick <= last;
                o    <= mode ? last : (cnt < hi);
                if (wrap) begin
                    cnt <= '0;
                    if (div_load) begin
                        div_cur <= div_clamped;
                    end else if (pending) begin
                        div_cur <= shadow;
                    end
                end else begin
                    cnt <= cnt + ONE;
                end
            end else begin
                tick <= 1'b0;
            end

            // A load coinciding with a wrap is applied directly and leaves nothing pending.
            if (div_load) begin
                shadow  <= div_clamped;
                pending <= !(en && wrap);
            end else if (en && wrap) begin
                pending <= 1'b0;
            end
        end
    end

endmodule
